pipe_input_arbiter: RTL and testbench
=====================================

// Module: pipe_input_arbiter
// PURPOSE
// Clocked two-requester arbiter sharing the input channel of the 3-stage bundled-data micropipeline.
// Each requester runs a 4-phase req/ack handshake with bundled data.
// The arbiter synchronises the asynchronous handshake inputs and grants requesters round-robin.
// It replays the winner's word onto the pipeline's req_in/data_in and returns ack to the winner.
// Also provides a transfer counter and a sticky timeout flag for a stalled pipeline.
// PARAMETERS
// DATA_W       3     width of each data word
// SYNC_STAGES  2     flops per synchroniser on req0_in, req1_in, ack_in (legal >=2)
// SETUP_CYC    2     cycles data_out is held stable before req_out rises (legal >=1)
// TIMEOUT      255   cycles waiting on any pipeline ack edge before timeout_err sets
// PORTS
// clk          in   1       clock
// rst          in   1       asynchronous active-high reset
// req0_in      in   1       requester 0 request (async, 4-phase)
// data0_in     in   DATA_W  requester 0 data, stable while req0_in high
// ack0_out     out  1       requester 0 acknowledge
// req1_in      in   1       requester 1 request (async, 4-phase)
// data1_in     in   DATA_W  requester 1 data, stable while req1_in high
// ack1_out     out  1       requester 1 acknowledge
// req_out      out  1       request to pipeline first stage
// ack_in       in   1       acknowledge from pipeline first stage (async)
// data_out     out  DATA_W  data to pipeline, registered
// grant_id     out  1       index of requester currently/last served
// busy         out  1       high in every state except IDLE
// xfer_cnt     out  8       completed transfers, wraps 255->0
// timeout_err  out  1       sticky; cleared only by rst
// BEHAVIOUR
// - Reset (async assert, released on a clk edge): all outputs 0 and synchroniser flops 0.
//   State IDLE, round-robin pointer rr=0 (requester 0 preferred), wait counter 0.
// - Synchronisers: req0_s, req1_s, ack_s are SYNC_STAGES-flop copies. The FSM uses only these.
// - IDLE: if req0_s|req1_s, pick a winner. With both high, the winner is rr; with one high, that one.
//   Latch its data into data_out, set grant_id, and go to SETUP. The counter loads SETUP_CYC-1.
// - SETUP: req_out=0. Decrement the counter; at 0 go to REQ_HI.
// - REQ_HI: req_out=1; stay until ack_s=1, then go to REQ_LO.
// - REQ_LO: req_out=0; stay until ack_s=0, then go to ACK_HI.
// - ACK_HI: ack<grant_id>_out=1; stay until req<grant_id>_s=0, then go to ACK_LO.
// - ACK_LO: ack<grant_id>_out=0 for exactly one cycle. Then:
//   - xfer_cnt+1 (mod 256);
//   - rr = ~grant_id;
//   - go to IDLE.
// - Only one ack output is ever high; the loser's request simply waits (no ack, no data capture).
// - data_out changes only on the IDLE->SETUP transition; held through ACK_LO and into IDLE.
// - Minimum latency from req_s high to req_out high: 1 + SETUP_CYC cycles.
// - Timeout: a wait counter runs in REQ_HI and REQ_LO and clears on every state change.
//   - On reaching TIMEOUT, timeout_err=1 (sticky).
//   - The FSM keeps waiting; there is no abort.
// - Winner's req drop before its ack: a protocol violation, so not handled. The FSM still follows the states above.
// - New request in IDLE on the ACK_LO->IDLE cycle is evaluated on the next cycle with the updated rr.
// - rst mid-transfer: immediate return to reset values. req_out and ack outputs drop asynchronously.
//   Requesters and the pipeline are reset by the same rst.
// TESTING
// - Reset, then req0_in=1 with data0_in=3'b101 and a pipeline model acking within 1 cycle:
//   - data_out=101;
//   - req_out rises 1+SETUP_CYC cycles after req0_s;
//   - ack0_out rises after ack_in falls;
//   - xfer_cnt=1;
//   - grant_id=0.
// - req0_in and req1_in raised the same cycle (data 3'b001 / 3'b110), both held until acked:
//   - served 0 then 1;
//   - data_out sequence 001,110;
//   - ack1_out never high while ack0_out is high.
// - Repeat the simultaneous case with rr=1 after the previous test: requester 1 is served first.
// - 300 back-to-back transfers alternating requesters: xfer_cnt wraps to 44; no lost or duplicated words at the pipeline output.
// - Pipeline ack_in held 0: timeout_err=1 after 255 cycles in REQ_HI. Then raise ack_in: the transfer completes and timeout_err stays 1.
// - Assert rst while in REQ_HI: req_out, ack0_out/ack1_out, busy, xfer_cnt, timeout_err all 0 before the next clk edge. The FSM restarts in IDLE.

Source files
------------

// File: rtl/pipe_input_arbiter_if.sv
// Handshake and data bundle between the two requesters, the arbiter and the
// first stage of the bundled-data micropipeline.
interface pipe_input_arbiter_if #(
  parameter int DATA_W = 3
);
  logic              req0_in;
  logic [DATA_W-1:0] data0_in;
  logic              ack0_out;
  logic              req1_in;
  logic [DATA_W-1:0] data1_in;
  logic              ack1_out;
  logic              req_out;
  logic              ack_in;
  logic [DATA_W-1:0] data_out;
  logic              grant_id;
  logic              busy;
  logic [7:0]        xfer_cnt;
  logic              timeout_err;

  // Arbiter side.
  modport slave (
    input  req0_in, data0_in, req1_in, data1_in, ack_in,
    output ack0_out, ack1_out, req_out, data_out, grant_id, busy,
           xfer_cnt, timeout_err
  );

  // Environment side: requesters plus pipeline first stage.
  modport master (
    output req0_in, data0_in, req1_in, data1_in, ack_in,
    input  ack0_out, ack1_out, req_out, data_out, grant_id, busy,
           xfer_cnt, timeout_err
  );
endinterface

// File: rtl/pipe_input_arbiter.sv
// Round-robin arbiter between two asynchronous 4-phase requesters feeding the
// bundled-data pipeline input. Handshake inputs are synchronised; the winning
// word is held on data_out for SETUP_CYC cycles before req_out rises. The
// pipeline's ack edges are awaited under a sticky, non-aborting timeout.
module pipe_input_arbiter #(
  parameter int DATA_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_input_arbiter_if.slave  bus
);

  localparam int SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_REQ_HI = 3'd2,
    S_REQ_LO = 3'd3,
    S_ACK_HI = 3'd4,
    S_ACK_LO = 3'd5
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_req0_sync;
  logic [SYNC_STAGES-1:0] r_req1_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [SC_W-1:0]        r_setup_cnt;
  logic [TO_W-1:0]        r_wait_cnt;
  logic                   r_rr;
  logic                   r_req_out;
  logic                   r_ack0_out;
  logic                   r_ack1_out;
  logic [DATA_W-1:0]      r_data_out;
  logic                   r_grant_id;
  logic                   r_busy;
  logic [7:0]             r_xfer_cnt;
  logic                   r_timeout_err;

  logic w_req0_s;
  logic w_req1_s;
  logic w_ack_s;
  logic w_pick;
  logic w_req_sel_s;
  logic w_wait_hit;
  logic w_wait_sat;

  assign w_req0_s = r_req0_sync[SYNC_STAGES-1];
  assign w_req1_s = r_req1_sync[SYNC_STAGES-1];
  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];

  // Shift the asynchronous handshake inputs through the synchroniser chains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req0_sync <= '0;
      r_req1_sync <= '0;
      r_ack_sync  <= '0;
    end else begin
      r_req0_sync <= {r_req0_sync[SYNC_STAGES-2:0], bus.req0_in};
      r_req1_sync <= {r_req1_sync[SYNC_STAGES-2:0], bus.req1_in};
      r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  // Winner selection (rr breaks ties) and the stall-timer thresholds.
  always_comb begin
    w_pick      = 1'b0;
    w_req_sel_s = 1'b0;
    if (w_req0_s && w_req1_s) begin
      w_pick = r_rr;
    end else if (w_req1_s) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
    if (r_grant_id) begin
      w_req_sel_s = w_req1_s;
    end else begin
      w_req_sel_s = w_req0_s;
    end
    w_wait_hit = (r_wait_cnt == TO_W'(TIMEOUT - 1));
    w_wait_sat = (r_wait_cnt == TO_W'(TIMEOUT));
  end

  // Arbitration FSM; all outputs are registered and change on transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_setup_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_rr          <= 1'b0;
      r_req_out     <= 1'b0;
      r_ack0_out    <= 1'b0;
      r_ack1_out    <= 1'b0;
      r_data_out    <= '0;
      r_grant_id    <= 1'b0;
      r_busy        <= 1'b0;
      r_xfer_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0_s || w_req1_s) begin
            r_data_out  <= w_pick ? bus.data1_in : bus.data0_in;
            r_grant_id  <= w_pick;
            r_setup_cnt <= SC_W'(SETUP_CYC - 1);
            r_busy      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_setup_cnt == '0) begin
            r_req_out  <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_REQ_HI;
          end else begin
            r_setup_cnt <= r_setup_cnt - SC_W'(1);
          end
        end
        S_REQ_HI: begin
          if (w_ack_s) begin
            r_req_out  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_REQ_LO;
          end else begin
            if (!w_wait_sat) r_wait_cnt <= r_wait_cnt + TO_W'(1);
            if (w_wait_hit) r_timeout_err <= 1'b1;
          end
        end
        S_REQ_LO: begin
          if (!w_ack_s) begin
            r_wait_cnt <= '0;
            r_ack0_out <= ~r_grant_id;
            r_ack1_out <= r_grant_id;
            r_state    <= S_ACK_HI;
          end else begin
            if (!w_wait_sat) r_wait_cnt <= r_wait_cnt + TO_W'(1);
            if (w_wait_hit) r_timeout_err <= 1'b1;
          end
        end
        S_ACK_HI: begin
          if (!w_req_sel_s) begin
            r_ack0_out <= 1'b0;
            r_ack1_out <= 1'b0;
            r_state    <= S_ACK_LO;
          end
        end
        S_ACK_LO: begin
          r_xfer_cnt <= r_xfer_cnt + 8'd1;
          r_rr       <= ~r_grant_id;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_req_out  <= 1'b0;
          r_ack0_out <= 1'b0;
          r_ack1_out <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_out     = r_req_out;
  assign bus.ack0_out    = r_ack0_out;
  assign bus.ack1_out    = r_ack1_out;
  assign bus.data_out    = r_data_out;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = r_busy;
  assign bus.xfer_cnt    = r_xfer_cnt;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipe_input_arbiter.sv
// Directed bench: two 4-phase requesters and a pipeline stage that acks one
// cycle after req_out, with a hold_ack signal to stall it.
module tb_pipe_input_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic hold_ack = 1'b0;
  logic prev_req = 1'b0;
  int   overlap_cnt = 0;
  logic [2:0] cap_q[$];

  pipe_input_arbiter_if #(.DATA_W(3)) bus ();

  pipe_input_arbiter #(
    .DATA_W(3), .SYNC_STAGES(2), .SETUP_CYC(2), .TIMEOUT(255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pipeline first stage: capture each word on req_out rise, ack a cycle later.
  always @(negedge clk) begin
    if (rst) begin
      bus.ack_in = 1'b0;
      prev_req   = 1'b0;
    end else begin
      if (bus.req_out && !prev_req) cap_q.push_back(bus.data_out);
      prev_req   = bus.req_out;
      bus.ack_in = hold_ack ? 1'b0 : bus.req_out;
    end
  end

  // Both acknowledges high together is never legal.
  always @(negedge clk) begin
    if (bus.ack0_out && bus.ack1_out) overlap_cnt++;
  end

  function automatic logic cur(input int sel);
    case (sel)
      0:       return bus.ack0_out;
      1:       return bus.ack1_out;
      default: return bus.req_out;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic level, input string name);
    int cyc;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (cur(sel) == level) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc < 0) begin
      failures++;
      $display("FAIL wait_%s: timed out, still %b, required %b", name, cur(sel), level);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] d);
    if (id == 0) begin
      bus.req0_in = v;
      if (v) bus.data0_in = d;
    end else begin
      bus.req1_in = v;
      if (v) bus.data1_in = d;
    end
  endtask

  task automatic xfer(input int id, input logic [2:0] d);
    @(negedge clk);
    set_req(id, 1'b1, d);
    wait_sig(id, 1'b1, "ack_hi");
    checks++;
    if (bus.grant_id !== id[0]) begin
      failures++;
      $display("FAIL xfer_grant: grant_id=%b required %b", bus.grant_id, id[0]);
    end
    set_req(id, 1'b0, d);
    wait_sig(id, 1'b0, "ack_lo");
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    hold_ack = 1'b0;
    bus.req0_in = 1'b0;
    bus.req1_in = 1'b0;
    bus.data0_in = 3'd0;
    bus.data1_in = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({bus.req_out, bus.ack0_out, bus.ack1_out, bus.data_out, bus.grant_id,
         bus.busy, bus.xfer_cnt, bus.timeout_err} !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b ack0=%b ack1=%b data=%b gid=%b busy=%b cnt=%0d to=%b required all 0",
               bus.req_out, bus.ack0_out, bus.ack1_out, bus.data_out, bus.grant_id,
               bus.busy, bus.xfer_cnt, bus.timeout_err);
    end
  endtask

  task automatic test_single;
    int rq_cyc, fall_cyc, ack_cyc;
    logic seen_hi;
    logic [2:0] d_at;
    rq_cyc = -1; fall_cyc = -1; ack_cyc = -1; seen_hi = 1'b0; d_at = 3'd0;
    cap_q.delete();
    @(negedge clk);
    set_req(0, 1'b1, 3'b101);
    for (int i = 1; i <= 100 && ack_cyc < 0; i++) begin
      @(negedge clk);
      if (rq_cyc < 0 && bus.req_out) begin
        rq_cyc = i;
        d_at = bus.data_out;
      end
      if (bus.ack_in) seen_hi = 1'b1;
      else if (seen_hi && fall_cyc < 0) fall_cyc = i;
      if (bus.ack0_out) ack_cyc = i;
    end
    checks++;
    if (rq_cyc != 5) begin
      failures++;
      $display("FAIL single_latency: req_out rose after %0d cycles, required 5", rq_cyc);
    end
    checks++;
    if (d_at !== 3'b101) begin
      failures++;
      $display("FAIL single_data: data_out=%b required 101", d_at);
    end
    checks++;
    if (fall_cyc < 0 || ack_cyc <= fall_cyc) begin
      failures++;
      $display("FAIL single_ack_order: ack0 at %0d, ack_in fall at %0d, required ack0 after fall", ack_cyc, fall_cyc);
    end
    set_req(0, 1'b0, 3'b101);
    wait_sig(0, 1'b0, "single_ack_lo");
    @(negedge clk);
    checks++;
    if (bus.xfer_cnt !== 8'd1 || bus.grant_id !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 3'b101) begin
      failures++;
      $display("FAIL single_done: cnt=%0d gid=%b busy=%b data=%b required 1 0 0 101",
               bus.xfer_cnt, bus.grant_id, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_simultaneous(input int first, input logic [2:0] d0, input logic [2:0] d1, input string name);
    int second;
    logic [2:0] exp0, exp1;
    second = 1 - first;
    exp0 = (first == 0) ? d0 : d1;
    exp1 = (first == 0) ? d1 : d0;
    cap_q.delete();
    overlap_cnt = 0;
    @(negedge clk);
    set_req(0, 1'b1, d0);
    set_req(1, 1'b1, d1);
    wait_sig(first, 1'b1, "sim_first_hi");
    checks++;
    if (bus.grant_id !== first[0] || cur(second) !== 1'b0) begin
      failures++;
      $display("FAIL %s_first: gid=%b other_ack=%b required gid=%0d other_ack=0", name, bus.grant_id, cur(second), first);
    end
    set_req(first, 1'b0, 3'd0);
    wait_sig(first, 1'b0, "sim_first_lo");
    wait_sig(second, 1'b1, "sim_second_hi");
    checks++;
    if (bus.grant_id !== second[0]) begin
      failures++;
      $display("FAIL %s_second: gid=%b required %0d", name, bus.grant_id, second);
    end
    set_req(second, 1'b0, 3'd0);
    wait_sig(second, 1'b0, "sim_second_lo");
    checks++;
    if (cap_q.size() != 2 || cap_q[0] !== exp0 || cap_q[1] !== exp1) begin
      failures++;
      $display("FAIL %s_data_seq: got %0d words first=%b second=%b required %b,%b", name,
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 3'bx, (cap_q.size() > 1) ? cap_q[1] : 3'bx, exp0, exp1);
    end
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL %s_ack_overlap: %0d cycles with both acks high, required 0", name, overlap_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] d;
    apply_reset();
    cap_q.delete();
    for (int i = 0; i < 300; i++) begin
      d = 3'(i) ^ 3'(i >> 3);
      xfer(i % 2, d);
    end
    @(negedge clk);
    checks++;
    if (bus.xfer_cnt !== 8'd44) begin
      failures++;
      $display("FAIL b2b_count: xfer_cnt=%0d required 44", bus.xfer_cnt);
    end
    checks++;
    if (cap_q.size() != 300) begin
      failures++;
      $display("FAIL b2b_words: %0d words at pipeline, required 300", cap_q.size());
    end
    for (int i = 0; i < 300 && i < cap_q.size(); i++) begin
      d = 3'(i) ^ 3'(i >> 3);
      checks++;
      if (cap_q[i] !== d) begin
        failures++;
        $display("FAIL b2b_word[%0d]: got %b required %b", i, cap_q[i], d);
      end
    end
  endtask

  task automatic test_timeout;
    apply_reset();
    hold_ack = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 3'b011);
    wait_sig(2, 1'b1, "to_req_out");
    repeat (254) @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.req_out !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%b req=%b after 254 cycles, required 0 1", bus.timeout_err, bus.req_out);
    end
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: err=%b after 255 cycles, required 1", bus.timeout_err);
    end
    hold_ack = 1'b0;
    wait_sig(0, 1'b1, "to_ack_hi");
    set_req(0, 1'b0, 3'b011);
    wait_sig(0, 1'b0, "to_ack_lo");
    @(negedge clk);
    checks++;
    if (bus.xfer_cnt !== 8'd1 || bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_complete: cnt=%0d err=%b required 1 1", bus.xfer_cnt, bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    hold_ack = 1'b1;
    @(negedge clk);
    set_req(1, 1'b1, 3'b100);
    wait_sig(2, 1'b1, "mid_req_out");
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_out, bus.ack0_out, bus.ack1_out, bus.busy, bus.xfer_cnt, bus.timeout_err} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid: req=%b ack0=%b ack1=%b busy=%b cnt=%0d err=%b required all 0",
               bus.req_out, bus.ack0_out, bus.ack1_out, bus.busy, bus.xfer_cnt, bus.timeout_err);
    end
    bus.req1_in = 1'b0;
    hold_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_out !== 1'b0) begin
      failures++;
      $display("FAIL restart_idle: busy=%b req=%b required 0 0", bus.busy, bus.req_out);
    end
    cap_q.delete();
    xfer(0, 3'b010);
    @(negedge clk);
    checks++;
    if (bus.xfer_cnt !== 8'd1 || cap_q.size() != 1 || bus.data_out !== 3'b010) begin
      failures++;
      $display("FAIL restart_xfer: cnt=%0d words=%0d data=%b required 1 1 010",
               bus.xfer_cnt, cap_q.size(), bus.data_out);
    end
  endtask

  initial begin
    bus.req0_in = 1'b0;
    bus.req1_in = 1'b0;
    bus.data0_in = 3'd0;
    bus.data1_in = 3'd0;
    test_reset();
    test_single();
    apply_reset();
    test_simultaneous(0, 3'b001, 3'b110, "sim_rr0");
    xfer(0, 3'b111);
    test_simultaneous(1, 3'b001, 3'b110, "sim_rr1");
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
